// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the uart_tx slice.
//   tx_state_t       : transmitter FSM state encoding (PARITY is only reached
//                      when the build defines UART_TX_PARITY_EN)
//   CSR_* constants  : bit positions inside the 32-bit status word
//   *_ADDR_DEF       : default IO addresses for the data register and CSR
//   sat_count3()     : clamps an occupancy value into the 3-bit CSR field
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int CSR_BUSY    = 0;
  localparam int CSR_FULL    = 1;
  localparam int CSR_EMPTY   = 2;
  localparam int CSR_OVF     = 3;
  localparam int CSR_CNT_LSB = 4;

  localparam logic [7:0] UART_IO_ADDR_DEF  = 8'h00;
  localparam logic [7:0] UART_CSR_ADDR_DEF = 8'h04;

  // The CSR occupancy field is only 3 bits wide, so deeper FIFOs report 7.
  function automatic logic [2:0] sat_count3(input int n);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous FIFO with a registered read head. The oldest entry is always
// presented on 'head' straight from a flop, so the consumer can pop and use
// the value in the same cycle without a memory read in the path.
//   clk, rst    : clock, synchronous active-high reset (flushes contents)
//   push        : write push_data (ignored while full)
//   push_data   : WIDTH-bit entry to enqueue
//   pop         : discard the head entry (ignored while empty)
//   head        : oldest entry, valid while !empty
//   full, empty : occupancy flags
//   count       : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = head_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array: no reset needed, entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the head register. The head is refreshed from the
  // next stored entry on a pop, or taken straight from push_data whenever the
  // pushed byte becomes the oldest entry (push into empty, or push while
  // popping the last remaining entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (do_pop) begin
        if (cnt_q > CW'(1)) begin
          head_q <= mem[rd_ptr + AW'(1)];
        end else if (do_push) begin
          head_q <= push_data;
        end
      end else if (do_push && empty) begin
        head_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Memory-mapped UART transmitter snooping the NextCore IO bus. Bytes written
// to UART_IO_ADDR are queued and sent 8N1, LSB first, CLK_DIV clocks per bit.
// Writing the CSR address with data bit 3 set clears the sticky overflow flag.
//   clk, rst      : clock, synchronous active-high reset
//   io_addr       : IO address of the current bus cycle
//   io_data       : IO write data (only [7:0] are queued, [3] clears overflow)
//   io_we         : one-cycle write strobe
//   uart_csr_reg  : registered status {count[6:4], ovf, empty, full, busy}
//   tx            : registered serial output, idle high
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11*CLK_DIV clock frames instead of 10).
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int         CLK_DIV       = 104,
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [7:0] UART_IO_ADDR  = UART_IO_ADDR_DEF,
  parameter logic [7:0] UART_CSR_ADDR = UART_CSR_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_data,
  input  logic        io_we,
  output logic [31:0] uart_csr_reg,
  output logic        tx
);

  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  tx_state_t   state_q, state_n;
  logic [15:0] baud_q, baud_n;
  logic [2:0]  idx_q, idx_n;
  logic [7:0]  data_q, data_n;
  logic        tx_q, tx_n;
  logic        ovf_q;
  logic [31:0] csr_q, csr_n;
  logic        pop;
  logic        bit_end;
  logic        push_req;
  logic        csr_wr;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        unused_data_bits;

  assign push_req         = io_we && (io_addr == UART_IO_ADDR);
  assign csr_wr           = io_we && (io_addr == UART_CSR_ADDR);
  assign bit_end          = (baud_q == '0);
  assign unused_data_bits = ^io_data[31:8];
  assign tx               = tx_q;
  assign uart_csr_reg     = csr_q;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (io_data[7:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // FSM state, baud counter, bit index, the frame's byte and the tx flop.
  // tx is computed from the next state so it changes on the same edge the
  // FSM moves, keeping the pin glitch-free and aligned to bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      tx_q    <= tx_n;
    end
  end

  // Next-state logic. Each bit lasts until the down-counter reaches zero, then
  // the counter reloads for the following bit. The FIFO is popped either from
  // IDLE or at the end of a stop bit, the latter giving back-to-back frames.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    idx_n   = idx_q;
    data_n  = data_q;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state_q)
      IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_n  = fifo_head;
          baud_n  = DIV_M1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = DIV_M1;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = DIV_M1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx_q + 3'd1;
          end
        end else begin
          baud_n = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_n  = DIV_M1;
          state_n = STOP;
        end else begin
          baud_n = baud_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_n  = fifo_head;
            baud_n  = DIV_M1;
            state_n = START;
          end else begin
            baud_n  = '0;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_q - 16'd1;
        end
      end
      default: begin
        baud_n  = '0;
        state_n = IDLE;
      end
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_n[idx_n];
      PARITY:  tx_n = ^data_n;
      default: tx_n = 1'b1;
    endcase
  end

  // Sticky overflow: a push that finds the FIFO full sets it, and a set in
  // the same cycle as a clear request takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (push_req && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (csr_wr && io_data[3]) begin
      ovf_q <= 1'b0;
    end
  end

  // Status word assembled from the current state and registered every cycle.
  always_comb begin
    csr_n                      = '0;
    csr_n[CSR_BUSY]            = (state_q != IDLE);
    csr_n[CSR_FULL]            = fifo_full;
    csr_n[CSR_EMPTY]           = fifo_empty;
    csr_n[CSR_OVF]             = ovf_q;
    csr_n[CSR_CNT_LSB +: 3]    = sat_count3(int'(fifo_count));
  end

  // Status register, reset to "empty" only.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_q <= 32'h0000_0004;
    end else begin
      csr_q <= csr_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx with CLK_DIV=4 and FIFO_DEPTH=4. A
// transaction-level reference model (byte queue plus a queue of expected
// line levels per clock) runs alongside the DUT and is compared every cycle;
// directed table vectors and hand sequences add fixed expectations.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  io_addr = 8'h00;
  logic [31:0] io_data = 32'h0;
  logic        io_we = 1'b0;
  logic [31:0] uart_csr_reg;
  logic        tx;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit check_en     = 1'b0;

  uart_tx #(
    .CLK_DIV       (DIV),
    .FIFO_DEPTH    (DEPTH),
    .UART_IO_ADDR  (8'h00),
    .UART_CSR_ADDR (8'h04)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_addr      (io_addr),
    .io_data      (io_data),
    .io_we        (io_we),
    .uart_csr_reg (uart_csr_reg),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  // Reference model state: queued bytes, remaining line levels of the frame
  // in flight, whether the line is currently carrying a frame, and overflow.
  logic [7:0]  mq[$];
  logic        wave[$];
  bit          in_frame = 1'b0;
  bit          ovf_m = 1'b0;
  logic        tx_exp = 1'b1;
  logic [31:0] csr_exp = 32'h4;
  logic [31:0] csr_next;
  logic [7:0]  mbyte;
  bit          full_pre;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One bus write lasting exactly one clock; called and returning on a negedge.
  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
    io_addr = addr;
    io_data = data;
    io_we   = 1'b1;
    @(negedge clk);
    io_we   = 1'b0;
    io_data = $urandom;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the model says everything has been transmitted.
  task automatic waitDrained();
    int k;
    k = 0;
    while ((mq.size() != 0 || wave.size() != 0 || in_frame) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_compared++;
    if (k >= 3000) begin
      n_mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d cycles, expected < 3000", k);
    end
    idleCycles(2);
  endtask

  // Model step on every clock edge: the status word reflects the state before
  // the edge; a new frame starts when the line is free and a byte is waiting.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      wave.delete();
      in_frame = 1'b0;
      ovf_m    = 1'b0;
      tx_exp   = 1'b1;
      csr_exp  = 32'h4;
    end else begin
      full_pre      = (mq.size() == DEPTH);
      csr_next      = 32'h0;
      csr_next[0]   = in_frame;
      csr_next[1]   = full_pre;
      csr_next[2]   = (mq.size() == 0);
      csr_next[3]   = ovf_m;
      csr_next[6:4] = (mq.size() > 7) ? 3'd7 : 3'(mq.size());
      if (wave.size() == 0 && mq.size() > 0) begin
        mbyte = mq.pop_front();
        for (int c = 0; c < DIV; c++) wave.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int c = 0; c < DIV; c++) wave.push_back(mbyte[b]);
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < DIV; c++) wave.push_back(^mbyte);
`endif
        for (int c = 0; c < DIV; c++) wave.push_back(1'b1);
      end
      if (wave.size() > 0) begin
        tx_exp   = wave.pop_front();
        in_frame = 1'b1;
      end else begin
        tx_exp   = 1'b1;
        in_frame = 1'b0;
      end
      if (io_we && io_addr == 8'h00) begin
        if (full_pre) ovf_m = 1'b1;
        else          mq.push_back(io_data[7:0]);
      end else if (io_we && io_addr == 8'h04 && io_data[3]) begin
        ovf_m = 1'b0;
      end
      csr_exp = csr_next;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_tx", {31'b0, tx}, {31'b0, tx_exp});
      checkOutput("model_csr", uart_csr_reg, csr_exp);
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    bit          sends;
    logic [7:0]  exp_bits;
    logic        exp_par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int r;
    logic expb;
    vecs[0] = '{8'h00, 32'hFFFF_FF55, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'h00, 32'h1234_560F, 1'b1, 8'h0F, 1'b0};
    vecs[2] = '{8'h00, 32'h0000_0007, 1'b1, 8'h07, 1'b1};
    vecs[3] = '{8'h00, 32'h0000_0003, 1'b1, 8'h03, 1'b0};
    vecs[4] = '{8'h00, 32'hABCD_EF80, 1'b1, 8'h80, 1'b1};
    vecs[5] = '{8'h08, 32'h0000_0055, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h04, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    $display("[TB] reset idle check");
    for (int i = 0; i < 20; i++) begin
      checkOutput("reset_tx", {31'b0, tx}, 32'h1);
      checkOutput("reset_csr", uart_csr_reg, 32'h4);
      @(negedge clk);
    end

    $display("[TB] table vectors");
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].addr, vecs[v].data);
      @(negedge clk);
      for (int j = 0; j < NBITS; j++) begin
        if (!vecs[v].sends)                    expb = 1'b1;
        else if (j == 0)                       expb = 1'b0;
        else if (j <= 8)                       expb = vecs[v].exp_bits[j-1];
        else if (NBITS == 11 && j == 9)        expb = vecs[v].exp_par;
        else                                   expb = 1'b1;
        for (int c = 0; c < DIV; c++) begin
          checkOutput($sformatf("vec%0d_bit%0d", v, j), {31'b0, tx}, {31'b0, expb});
          if (c == 1)
            checkOutput($sformatf("vec%0d_busy", v), {31'b0, uart_csr_reg[0]},
                        {31'b0, vecs[v].sends});
          @(negedge clk);
        end
      end
      idleCycles(1);
      checkOutput($sformatf("vec%0d_csr_after", v), uart_csr_reg, 32'h4);
    end

    $display("[TB] overflow sequence");
    for (int i = 0; i < 6; i++) applyStimulus(8'h00, 32'h0000_00A1 + 32'(i));
    checkOutput("full_csr", uart_csr_reg, 32'h43);
    @(negedge clk);
    checkOutput("ovf_csr", uart_csr_reg, 32'h4B);
    applyStimulus(8'h04, 32'h0000_0008);
    checkOutput("ovf_clear_lag", uart_csr_reg, 32'h4B);
    @(negedge clk);
    checkOutput("ovf_cleared", uart_csr_reg, 32'h43);
    waitDrained();
    checkOutput("after_ovf_csr", uart_csr_reg, 32'h4);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h00, 32'h0000_000F);
    applyStimulus(8'h00, 32'h0000_0011);
    applyStimulus(8'h00, 32'h0000_0022);
    idleCycles(6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_tx", {31'b0, tx}, 32'h1);
    checkOutput("midreset_csr", uart_csr_reg, 32'h4);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("post_reset_tx", {31'b0, tx}, 32'h1);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 15);
      if (r < 2)       applyStimulus(8'h00, $urandom);
      else if (r == 2) applyStimulus(8'h04, $urandom);
      else if (r == 3) applyStimulus(8'(($urandom_range(1, 63)) * 4 + 1), $urandom);
      else             @(negedge clk);
    end
    waitDrained();
    applyStimulus(8'h04, 32'h8);
    idleCycles(3);
    checkOutput("final_csr", uart_csr_reg, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
